// File: rtl/lutram_fifo128.sv
// 128-entry synchronous FIFO over a WIDTH-wide bank of 128x1 distributed-RAM cells.
// Asynchronous RAM read feeds a registered RD_DATA so the consumer never sees the RAM path.
module lutram_fifo128 #(
   parameter int WIDTH         = 8,
   parameter int AFULL_THRESH  = 120,
   parameter int AEMPTY_THRESH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             WR_EN,
   input  logic [WIDTH-1:0] WR_DATA,
   output logic             FULL,
   output logic             ALMOST_FULL,
   input  logic             RD_EN,
   output logic [WIDTH-1:0] RD_DATA,
   output logic             RD_VALID,
   output logic             EMPTY,
   output logic             ALMOST_EMPTY,
   output logic [7:0]       COUNT,
   output logic             OVF,
   output logic             UDF
);

   localparam logic [7:0] AFULL_C  = 8'(AFULL_THRESH);
   localparam logic [7:0] AEMPTY_C = 8'(AEMPTY_THRESH);

   logic [6:0]       wr_ptr_r;
   logic [6:0]       rd_ptr_r;
   logic [7:0]       count_r;
   logic [WIDTH-1:0] rd_data_r;
   logic             rd_valid_r;
   logic             ovf_r;
   logic             udf_r;

   logic             full_s;
   logic             empty_s;
   logic             wr_acc_s;
   logic             rd_acc_s;
   logic [7:0]       count_nxt_s;
   logic [WIDTH-1:0] rd_word_s;

   // Flag decode from the count register only, so no request input reaches an output.
   always_comb begin
      full_s  = (count_r == 8'd128);
      empty_s = (count_r == 8'd0);
   end

   // Accept qualification and next occupancy; at full a paired read frees the slot only next cycle.
   always_comb begin
      wr_acc_s    = WR_EN && !full_s;
      rd_acc_s    = RD_EN && !empty_s;
      count_nxt_s = count_r;
      case ({wr_acc_s, rd_acc_s})
         2'b10:   count_nxt_s = count_r + 8'd1;
         2'b01:   count_nxt_s = count_r - 8'd1;
         default: count_nxt_s = count_r;
      endcase
   end

   // One 128x1 cell per data bit: clocked write, asynchronous read; contents survive reset.
   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [127:0] cell_r;

      // Cell write port.
      always_ff @(posedge CLK) begin
         if (wr_acc_s) begin
            cell_r[wr_ptr_r] <= WR_DATA[b];
         end
      end

      assign rd_word_s[b] = cell_r[rd_ptr_r];
   end

   // Pointers, occupancy, read register and sticky error bits.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_r   <= 7'd0;
         rd_ptr_r   <= 7'd0;
         count_r    <= 8'd0;
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
         ovf_r      <= 1'b0;
         udf_r      <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         if (wr_acc_s) begin
            wr_ptr_r <= wr_ptr_r + 7'd1;
         end
         if (rd_acc_s) begin
            rd_ptr_r   <= rd_ptr_r + 7'd1;
            rd_data_r  <= rd_word_s;
            rd_valid_r <= 1'b1;
         end else begin
            rd_valid_r <= 1'b0;
         end
         if (WR_EN && full_s) begin
            ovf_r <= 1'b1;
         end
         if (RD_EN && empty_s) begin
            udf_r <= 1'b1;
         end
      end
   end

   assign FULL         = full_s;
   assign EMPTY        = empty_s;
   assign ALMOST_FULL  = (count_r >= AFULL_C);
   assign ALMOST_EMPTY = (count_r <= AEMPTY_C);
   assign COUNT        = count_r;
   assign RD_DATA      = rd_data_r;
   assign RD_VALID     = rd_valid_r;
   assign OVF          = ovf_r;
   assign UDF          = udf_r;

endmodule
